// File: rtl/fht_pkg.sv
// Shared types and size helpers for the FHT stage controller.
package fht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } fht_state_e;

    localparam int DEF_LOG_N   = 8;
    localparam int DEF_BUT_LAT = 2;

    // Transform length N = 2**log_n.
    function automatic int fht_n(input int log_n);
        return 1 << log_n;
    endfunction

    // Width of a data-memory address (0..N-1).
    function automatic int fht_addr_w(input int log_n);
        return log_n;
    endfunction

    // Width of a twiddle ROM index (0..N/2-1).
    function automatic int fht_tw_w(input int log_n);
        return log_n - 1;
    endfunction

    // Width of a counter that must hold 0..lat.
    function automatic int fht_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/fht_wr_delay.sv
// Fixed-depth shift register that carries the write strobe and the two
// destination addresses alongside the butterfly pipeline.
module fht_wr_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DEPTH];

    // Shift one tap per cycle; reset flushes the line so no stale write escapes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fht_stage_ctrl.sv
// Address and control sequencer for an in-place radix-2 FHT.
// One butterfly is issued per RUN cycle; after each stage the controller
// waits BUT_LAT cycles (DRAIN) so the last results land before the banks
// swap and the next stage starts reading them.
// Handshake: iSTART is a level sampled only in IDLE; there is no ready
// signal, the request is taken on the first IDLE edge it is seen high and
// oBUSY rises on the following cycle.
module fht_stage_ctrl
    import fht_pkg::*;
#(
    parameter int LOG_N   = DEF_LOG_N,
    parameter int BUT_LAT = DEF_BUT_LAT
) (
    input  logic                       iCLK,
    input  logic                       iRESET,
    input  logic                       iSTART,
    output logic                       oBUSY,
    output logic                       oDONE,
    output logic                       oRD_VAL,
    output logic [LOG_N-1:0]           oRD_ADDR_0,
    output logic [LOG_N-1:0]           oRD_ADDR_1,
    output logic [LOG_N-1:0]           oRD_ADDR_2,
    output logic [LOG_N-2:0]           oW_ADDR,
    output logic                       oWR_EN,
    output logic [LOG_N-1:0]           oWR_ADDR_0,
    output logic [LOG_N-1:0]           oWR_ADDR_1,
    output logic                       oBANK,
    output logic [$clog2(LOG_N)-1:0]   oSTAGE,
    output logic [1:0]                 oSTATE
);

    localparam int AW = fht_addr_w(LOG_N);
    localparam int KW = fht_tw_w(LOG_N);
    localparam int SW = $clog2(LOG_N);
    localparam int DW = fht_cnt_w(BUT_LAT);
    localparam int PW = 1 + 2 * AW;

    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [SW-1:0] KW_S      = SW'(KW);
    localparam logic [SW-1:0] LAST_S    = SW'(LOG_N - 1);
    localparam logic [DW-1:0] LAST_D    = DW'(BUT_LAT - 1);

    fht_state_e        state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [AW-1:0]     b_q, b_d;
    logic [KW-1:0]     n_q, n_d;
    logic [DW-1:0]     d_q, d_d;
    logic              bank_q, bank_d;

    logic [AW-1:0]     half;
    logic [AW-1:0]     mask;
    logic [AW-1:0]     n_ext;
    logic [AW-1:0]     blk_span;
    logic              last_n;
    logic              last_b;
    logic              last_issue;
    logic [SW-1:0]     k_shift;
    logic              rd_val;
    logic [AW-1:0]     addr0, addr1, addr2;
    logic [KW-1:0]     k_idx;
    logic [PW-1:0]     wr_in, wr_out;

    // Per-stage geometry and the butterfly addresses for the current issue.
    always_comb begin
        half       = ONE_A << s_q;
        mask       = half - ONE_A;
        blk_span   = half | mask;
        n_ext      = {1'b0, n_q};
        last_n     = (n_ext == mask);
        // b is a multiple of 2*half, so the last block has every bit above s set.
        last_b     = ((b_q | blk_span) == {AW{1'b1}});
        last_issue = last_n && last_b;
        k_shift    = KW_S - s_q;
        rd_val     = (state_q == ST_RUN);
        addr0      = '0;
        addr1      = '0;
        addr2      = '0;
        k_idx      = '0;
        if (rd_val) begin
            addr0 = b_q + n_ext;
            addr1 = b_q + half + n_ext;
            addr2 = b_q + half + ((half - n_ext) & mask);
            k_idx = n_q << k_shift;
        end
    end

    // State and loop-counter register.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            d_q     <= '0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            n_q     <= n_d;
            d_q     <= d_d;
            bank_q  <= bank_d;
        end
    end

    // Next state: walk n inside a block, blocks inside a stage, then drain and swap banks.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        n_d     = n_q;
        d_d     = d_q;
        bank_d  = bank_q;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    b_d     = '0;
                    n_d     = '0;
                    d_d     = '0;
                end
            end
            ST_RUN: begin
                if (last_n) begin
                    n_d = '0;
                    b_d = b_q + (half << 1);
                end else begin
                    n_d = n_q + KW'(1);
                end
                if (last_issue) begin
                    state_d = ST_DRAIN;
                    d_d     = '0;
                end
            end
            ST_DRAIN: begin
                if (d_q == LAST_D) begin
                    bank_d = ~bank_q;
                    n_d    = '0;
                    b_d    = '0;
                    d_d    = '0;
                    if (s_q == LAST_S) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                        s_d     = s_q + SW'(1);
                    end
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wr_in = {rd_val, addr0, addr1};

    fht_wr_delay #(
        .DEPTH (BUT_LAT),
        .W     (PW)
    ) u_wr_delay (
        .clk_i (iCLK),
        .rst_i (iRESET),
        .d_i   (wr_in),
        .q_o   (wr_out)
    );

    assign oBUSY      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign oDONE      = (state_q == ST_FIN);
    assign oRD_VAL    = rd_val;
    assign oRD_ADDR_0 = addr0;
    assign oRD_ADDR_1 = addr1;
    assign oRD_ADDR_2 = addr2;
    assign oW_ADDR    = k_idx;
    assign oWR_EN     = wr_out[PW-1];
    assign oWR_ADDR_0 = wr_out[2*AW-1:AW];
    assign oWR_ADDR_1 = wr_out[AW-1:0];
    assign oBANK      = bank_q;
    assign oSTAGE     = s_q;
    assign oSTATE     = state_q;

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Bench for fht_stage_ctrl: an 8-point (LOG_N=3) and a 256-point (LOG_N=8)
// instance, both with a two-cycle butterfly.
module tb_fht_stage_ctrl;
    import fht_pkg::*;

    typedef struct packed {
        int busy; int done; int rd_val;
        int a0; int a1; int a2; int k;
        int wr_en; int w0; int w1;
        int bank; int stage;
    } obs_t;

    typedef struct {
        int cyc; int a0; int a1; int a2; int k; int stage;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic rst3, start3, busy3, done3, rdv3, wre3, bank3;
    logic [2:0] ra0_3, ra1_3, ra2_3, wa0_3, wa1_3;
    logic [1:0] tw3, stage3, state3;

    logic rst8, start8, busy8, done8, rdv8, wre8, bank8;
    logic [7:0] ra0_8, ra1_8, ra2_8, wa0_8, wa1_8;
    logic [6:0] tw8;
    logic [2:0] stage8;
    logic [1:0] state8;

    fht_stage_ctrl #(.LOG_N(3), .BUT_LAT(2)) dut3 (
        .iCLK(clk), .iRESET(rst3), .iSTART(start3),
        .oBUSY(busy3), .oDONE(done3), .oRD_VAL(rdv3),
        .oRD_ADDR_0(ra0_3), .oRD_ADDR_1(ra1_3), .oRD_ADDR_2(ra2_3),
        .oW_ADDR(tw3), .oWR_EN(wre3), .oWR_ADDR_0(wa0_3), .oWR_ADDR_1(wa1_3),
        .oBANK(bank3), .oSTAGE(stage3), .oSTATE(state3)
    );

    fht_stage_ctrl #(.LOG_N(8), .BUT_LAT(2)) dut8 (
        .iCLK(clk), .iRESET(rst8), .iSTART(start8),
        .oBUSY(busy8), .oDONE(done8), .oRD_VAL(rdv8),
        .oRD_ADDR_0(ra0_8), .oRD_ADDR_1(ra1_8), .oRD_ADDR_2(ra2_8),
        .oW_ADDR(tw8), .oWR_EN(wre8), .oWR_ADDR_0(wa0_8), .oWR_ADDR_1(wa1_8),
        .oBANK(bank8), .oSTAGE(stage8), .oSTATE(state8)
    );

    // ---------------- scoreboard state ----------------
    int   n_checks = 0;
    int   n_err    = 0;
    obs_t exp_q[$];
    obs_t hist[$];
    int   done_at;
    int   wr_cnt8 = 0;
    int   exp_bank3;
    int   exp_stage3;

    always @(negedge clk) if (wre8) wr_cnt8++;

    function automatic string fmt(input obs_t o);
        return $sformatf("bz%0d dn%0d rv%0d a%0d/%0d/%0d k%0d we%0d w%0d/%0d bk%0d st%0d",
                         o.busy, o.done, o.rd_val, o.a0, o.a1, o.a2, o.k,
                         o.wr_en, o.w0, o.w1, o.bank, o.stage);
    endfunction

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got [%s] expected [%s]", name, fmt(act), fmt(want));
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        o = '0;
        if (sel == 0) begin
            o.busy = int'(busy3); o.done = int'(done3); o.rd_val = int'(rdv3);
            o.a0 = int'(ra0_3); o.a1 = int'(ra1_3); o.a2 = int'(ra2_3); o.k = int'(tw3);
            o.wr_en = int'(wre3); o.w0 = int'(wa0_3); o.w1 = int'(wa1_3);
            o.bank = int'(bank3); o.stage = int'(stage3);
        end else begin
            o.busy = int'(busy8); o.done = int'(done8); o.rd_val = int'(rdv8);
            o.a0 = int'(ra0_8); o.a1 = int'(ra1_8); o.a2 = int'(ra2_8); o.k = int'(tw8);
            o.wr_en = int'(wre8); o.w0 = int'(wa0_8); o.w1 = int'(wa1_8);
            o.bank = int'(bank8); o.stage = int'(stage8);
        end
        return o;
    endfunction

    function automatic obs_t idle_obs(input int bank, input int stage);
        obs_t o;
        o = '0;
        o.bank = bank;
        o.stage = stage;
        return o;
    endfunction

    // ---------------- reference model ----------------
    // Expected per-cycle outputs of one transform, cycle 1 = first cycle after
    // the accepting edge. Built from the loop nest of the algorithm; writes are
    // the reads shifted by lat cycles. Ends with the FIN cycle and one IDLE cycle.
    task automatic build_run(input int log_n, input int lat, input int bank0);
        obs_t tl[$];
        obs_t rec;
        int nn, half;
        nn = 1 << log_n;
        for (int s = 0; s < log_n; s++) begin
            half = 1 << s;
            for (int b = 0; b < nn; b += 2 * half) begin
                for (int n = 0; n < half; n++) begin
                    rec = '0;
                    rec.busy = 1; rec.rd_val = 1;
                    rec.a0 = b + n;
                    rec.a1 = b + half + n;
                    rec.a2 = b + half + ((half - n) % half);
                    rec.k  = n * (nn / (2 * half));
                    rec.bank = bank0 ^ (s % 2);
                    rec.stage = s;
                    tl.push_back(rec);
                end
            end
            for (int d = 0; d < lat; d++) begin
                rec = '0;
                rec.busy = 1;
                rec.bank = bank0 ^ (s % 2);
                rec.stage = s;
                tl.push_back(rec);
            end
        end
        rec = '0;
        rec.done = 1;
        rec.bank = bank0 ^ (log_n % 2);
        rec.stage = log_n - 1;
        tl.push_back(rec);
        rec.done = 0;
        tl.push_back(rec);
        exp_q.delete();
        for (int t = 0; t < tl.size(); t++) begin
            rec = tl[t];
            if (t >= lat) begin
                rec.wr_en = tl[t-lat].rd_val;
                rec.w0    = tl[t-lat].a0;
                rec.w1    = tl[t-lat].a1;
            end
            exp_q.push_back(rec);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start3 = v; else start8 = v;
    endtask

    // Compares the first ncyc expected cycles (all when ncyc < 0). Call with
    // iSTART already raised before the accepting edge.
    task automatic check_timeline(input int sel, input string tag, input int ncyc,
                                  input bit drop_first, input bit drop_last);
        obs_t got;
        int lim;
        lim = (ncyc < 0 || ncyc > exp_q.size()) ? exp_q.size() : ncyc;
        hist.delete();
        done_at = 0;
        for (int t = 0; t < lim; t++) begin
            @(negedge clk);
            got = sample(sel);
            hist.push_back(got);
            if (got.done != 0 && done_at == 0) done_at = t + 1;
            chk_obs($sformatf("%s_c%0d", tag, t + 1), got, exp_q[t]);
            if (t == 0 && drop_first) set_start(sel, 1'b0);
            if (t == lim - 1 && drop_last) set_start(sel, 1'b0);
        end
    endtask

    // ---------------- test ----------------
    vec_t tab[8];
    obs_t zero_obs;
    int   gap, r, wr_base;
    bit   pulse;

    initial begin
        zero_obs = '0;
        tab[0] = '{7,  0, 2, 2, 0, 1};
        tab[1] = '{8,  1, 3, 3, 2, 1};
        tab[2] = '{9,  4, 6, 6, 0, 1};
        tab[3] = '{10, 5, 7, 7, 2, 1};
        tab[4] = '{13, 0, 4, 4, 0, 2};
        tab[5] = '{14, 1, 5, 7, 1, 2};
        tab[6] = '{15, 2, 6, 6, 2, 2};
        tab[7] = '{16, 3, 7, 5, 3, 2};

        rst3 = 1'b1; rst8 = 1'b1; start3 = 1'b0; start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk_obs("reset_d3", sample(0), zero_obs);
        chk("reset_state_d3", int'(state3), int'(ST_IDLE));
        chk_obs("reset_d8", sample(1), zero_obs);
        rst3 = 1'b0; rst8 = 1'b0;
        exp_bank3 = 0; exp_stage3 = 0;

        // Basic 8-point transform with a one-cycle start pulse.
        build_run(3, 2, exp_bank3);
        @(negedge clk); start3 = 1'b1;
        check_timeline(0, "basic", -1, 1, 0);
        exp_bank3 ^= 1; exp_stage3 = 2;
        chk("basic_busy_c1", hist[0].busy, 1);
        chk("basic_done_at", done_at, 19);
        chk("basic_final_bank", hist[18].bank, 1);
        chk("basic_busy_fin", hist[18].busy, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tab%0d_rv", i), hist[tab[i].cyc-1].rd_val, 1);
            chk($sformatf("tab%0d_a0", i), hist[tab[i].cyc-1].a0, tab[i].a0);
            chk($sformatf("tab%0d_a1", i), hist[tab[i].cyc-1].a1, tab[i].a1);
            chk($sformatf("tab%0d_a2", i), hist[tab[i].cyc-1].a2, tab[i].a2);
            chk($sformatf("tab%0d_k", i), hist[tab[i].cyc-1].k, tab[i].k);
            chk($sformatf("tab%0d_stage", i), hist[tab[i].cyc-1].stage, tab[i].stage);
            chk($sformatf("tab%0d_we", i), hist[tab[i].cyc+1].wr_en, 1);
            chk($sformatf("tab%0d_w0", i), hist[tab[i].cyc+1].w0, tab[i].a0);
            chk($sformatf("tab%0d_w1", i), hist[tab[i].cyc+1].w1, tab[i].a1);
        end

        // Reset and start together: reset wins, start is not remembered.
        @(negedge clk); rst3 = 1'b1; start3 = 1'b1;
        @(negedge clk);
        chk_obs("rst_start_c1", sample(0), zero_obs);
        rst3 = 1'b0; start3 = 1'b0;
        exp_bank3 = 0; exp_stage3 = 0;
        @(negedge clk);
        chk("rst_start_busy", int'(busy3), 0);
        chk("rst_start_rdval", int'(rdv3), 0);

        // Abort in the middle of stage 1, then a clean run from bank 0.
        build_run(3, 2, 0);
        @(negedge clk); start3 = 1'b1;
        check_timeline(0, "abort", 8, 1, 0);
        rst3 = 1'b1;
        @(negedge clk);
        chk_obs("abort_zero", sample(0), zero_obs);
        chk("abort_state", int'(state3), int'(ST_IDLE));
        rst3 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", int'(done3), 0);
        end
        build_run(3, 2, 0);
        @(negedge clk); start3 = 1'b1;
        check_timeline(0, "post_abort", -1, 1, 0);
        chk("post_abort_done_at", done_at, 19);
        chk("post_abort_bank0", hist[0].bank, 0);
        exp_bank3 = 1; exp_stage3 = 2;

        // iSTART held across two transforms: second starts only from IDLE.
        build_run(3, 2, exp_bank3);
        @(negedge clk); start3 = 1'b1;
        check_timeline(0, "hold1", -1, 0, 0);
        exp_bank3 ^= 1;
        build_run(3, 2, exp_bank3);
        check_timeline(0, "hold2", -1, 0, 1);
        exp_bank3 ^= 1;
        repeat (2) begin
            @(negedge clk);
            chk_obs("hold_idle", sample(0), idle_obs(exp_bank3, exp_stage3));
        end

        // Randomized gaps, start widths and aborts.
        for (int it = 0; it < 10; it++) begin
            gap = $urandom_range(0, 4);
            repeat (gap) begin
                @(negedge clk);
                chk_obs($sformatf("rand%0d_idle", it), sample(0), idle_obs(exp_bank3, exp_stage3));
            end
            build_run(3, 2, exp_bank3);
            @(negedge clk); start3 = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(1, 19);
                check_timeline(0, $sformatf("rand%0d_abort", it), r, 1, 0);
                rst3 = 1'b1;
                @(negedge clk);
                chk_obs($sformatf("rand%0d_abort_zero", it), sample(0), zero_obs);
                rst3 = 1'b0;
                exp_bank3 = 0; exp_stage3 = 0;
            end else begin
                pulse = ($urandom_range(0, 1) == 1);
                check_timeline(0, $sformatf("rand%0d_run", it), -1, pulse, 1);
                chk($sformatf("rand%0d_done_at", it), done_at, 19);
                exp_bank3 ^= 1; exp_stage3 = 2;
            end
        end

        // 256-point transform: every issue, latency and write-strobe count.
        build_run(8, 2, 0);
        wr_base = wr_cnt8;
        @(negedge clk); start8 = 1'b1;
        check_timeline(1, "n256", -1, 1, 0);
        chk("n256_done_at", done_at, 8 * (128 + 2) + 1);
        chk("n256_wr_count", wr_cnt8 - wr_base, 1024);
        chk("n256_final_bank", int'(bank8), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fht_stage_ctrl.md
FHT_STAGE_CTRL -- requirements
Module: fht_stage_ctrl

Interface
REQ-001 Parameter LOG_N, default 8, log2 of transform length N (N = 2**LOG_N, LOG_N >= 2).
REQ-002 Parameter BUT_LAT, default 2, fht_but latency in cycles from read-address issue to result valid (>= 1).
REQ-003 iCLK  in  1  single clock, all logic on rising edge.
REQ-004 iRESET  in  1  synchronous, active-high reset.
REQ-005 iSTART  in  1  start request; sampled only in IDLE.
REQ-006 oBUSY  out  1  high from the cycle after an accepted iSTART until oDONE is asserted.
REQ-007 oDONE  out  1  one-cycle pulse when the transform completes.
REQ-008 oRD_VAL  out  1  read addresses and twiddle address are valid this cycle.
REQ-009 oRD_ADDR_0 / oRD_ADDR_1 / oRD_ADDR_2  out  LOG_N each  butterfly inputs x0, x1, x2.
REQ-010 oW_ADDR  out  LOG_N-1  twiddle ROM index k (cos/sin of 2*pi*k/N).
REQ-011 oWR_EN  out  1  write strobe for y0/y1.
REQ-012 oWR_ADDR_0 / oWR_ADDR_1  out  LOG_N each  destinations of y0 and y1.
REQ-013 oBANK  out  1  ping-pong read bank; the write bank is ~oBANK.
REQ-014 oSTAGE  out  $clog2(LOG_N)  current stage index s.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and FIN.
- IDLE -> RUN on iSTART.
- RUN -> DRAIN after the last issue of the stage.
- DRAIN -> RUN (next stage) or FIN (last stage) after BUT_LAT cycles.
- FIN -> IDLE after one cycle.
REQ-016 Stage s SHALL use half = 2**s for s = 0..LOG_N-1, iterating block base b = 0, 2*half, ... and n = 0..half-1 within each block, one butterfly per cycle, N/2 issues per stage.
REQ-017 For each issue, the read and twiddle addresses SHALL be:
- oRD_ADDR_0 = b+n
- oRD_ADDR_1 = b+half+n
- oRD_ADDR_2 = b+half+((half-n) mod half)
- oW_ADDR = n*(N/(2*half))
REQ-018 oRD_VAL SHALL be high on every RUN cycle and low otherwise; the first issue SHALL occur in the first RUN cycle.
REQ-019 oWR_EN, oWR_ADDR_0 and oWR_ADDR_1 SHALL equal oRD_VAL, oRD_ADDR_0 and oRD_ADDR_1 delayed by exactly BUT_LAT cycles, including across stage boundaries and during DRAIN.
REQ-020 At the DRAIN exit, oBANK SHALL toggle and oSTAGE SHALL increment (except on the last stage), so the first issue of the next stage reads the bank just written.
REQ-021 oDONE SHALL pulse in the FIN cycle, which is the cycle after the last oWR_EN.
- oBUSY SHALL fall in the same cycle.
- oBANK SHALL hold its toggled value in IDLE, marking the bank that contains the result (LOG_N mod 2).
REQ-022 Total latency from the accepted iSTART edge to oDONE SHALL be LOG_N*(N/2+BUT_LAT)+1 cycles.
REQ-023 iSTART SHALL be ignored while oBUSY=1, and also in FIN.
REQ-024 All counters SHALL wrap with no out-of-range addresses; the n, b and s counters SHALL be unsigned, and the modulo in REQ-017 SHALL be computed as a (LOG_N)-bit mask on half-1.
REQ-025 Bit-reversed loading of the input and the memory write datapath are out of scope.

Reset
REQ-026 While iRESET=1, the next edge SHALL force IDLE and clear all outputs, oBANK, oSTAGE and the delay line to 0; any transform in progress is aborted with no oDONE.
REQ-027 If iRESET and iSTART are high together, reset SHALL win; a start is accepted only on a later cycle with iRESET=0.

Structure
REQ-028 Package fht_pkg SHALL hold the state enum typedef and the localparam helpers N = 2**LOG_N and the address widths.
REQ-029 Sub-module fht_wr_delay SHALL be a BUT_LAT-deep shift register for {valid, addr0, addr1} with synchronous reset.

Verification
REQ-030 Bench configuration LOG_N=3, BUT_LAT=2: pulse iSTART -> oBUSY=1 next cycle; oDONE after 3*(4+2)+1 = 19 cycles; final oBANK=1.
REQ-031 Stage 1, same configuration -> (addr0, addr1, addr2, k) issues are (0,2,2,0), (1,3,3,2), (4,6,6,0), (5,7,7,2).
REQ-032 Stage 2 -> issues are (0,4,4,0), (1,5,7,1), (2,6,6,2), (3,7,5,3); each oWR_EN occurs exactly 2 cycles after the matching oRD_VAL with the same addresses.
REQ-033 iSTART held high for the entire run -> exactly one transform runs; a second transform starts only from IDLE, one cycle after oDONE.
REQ-034 iRESET pulsed for 1 cycle in the middle of stage 1 -> all outputs 0 and IDLE on the next cycle; no oDONE; a following iSTART gives the full 19-cycle run starting from oBANK=0.
REQ-035 LOG_N=8, BUT_LAT=2 -> the scoreboard checks every issue against REQ-017; 8*130+1 = 1041 cycles to oDONE; exactly 1024 write strobes.
